// File: rtl/my_serial_dec16_if.sv
// Handshake bundle for the bit-serial decrementer: operand in, result and underflow out.
// Bit 15 of in/out is the least significant bit.
interface my_serial_dec16_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        underflow;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, underflow
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, underflow
  );
endinterface

// File: rtl/my_serial_dec16.sv
// Bit-serial 16-bit decrementer: one bit per clock through a single borrow flop,
// LSB (index 15) first, fixed 16-cycle latency, registered valid/ready on both sides.
module my_serial_dec16 (
  input  logic               clk,
  input  logic               reset_n,
  my_serial_dec16_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] work_q;
  logic [15:0] res_q;
  logic [3:0]  cnt_q;
  logic        borrow_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [15:0] out_q;
  logic        underflow_q;

  logic [3:0]  k_d;
  logic        bit_d;
  logic        borrow_d;
  logic [15:0] res_d;

  // Index of the bit handled this cycle; counts down from the LSB at index 15.
  always_comb begin
    k_d         = 4'd15 - cnt_q;
    bit_d       = work_q[k_d];
    borrow_d    = borrow_q & ~bit_d;
    res_d       = res_q;
    res_d[k_d]  = bit_d ^ borrow_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            work_q     <= bus.in;
            borrow_q   <= 1'b1;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          res_q    <= res_d;
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + 4'd1;
          // Visible outputs only move on the edge that finishes bit 0.
          if (cnt_q == 4'd15) begin
            out_q       <= res_d;
            underflow_q <= borrow_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_my_serial_dec16.sv
// Directed bench for my_serial_dec16 with a result scoreboard queue.
module tb_my_serial_dec16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  my_serial_dec16_if bus ();

  my_serial_dec16 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] out;
    logic        uf;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Numeric value -> bus vector (bit 15 is the LSB).
  function automatic logic [15:0] rv(input logic [15:0] n);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[15-i] = n[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [15:0] num, input string tag);
    int   w;
    exp_t e;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in       = rv(num);
    bus.in_valid = 1'b1;
    e.out        = rv(num - 16'd1);
    e.uf         = (num == 16'd0);
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Waits for out_valid after an accept; optionally jams new operands during SHIFT.
  task automatic wait_out(input string tag, input bit jam);
    int          lat;
    int          bad;
    logic [15:0] held;
    lat  = 0;
    bad  = 0;
    held = bus.out;
    while (!bus.out_valid && lat < 40) begin
      if (jam) begin
        bus.in       = 16'($urandom);
        bus.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
      if (!bus.out_valid && (bus.in_ready !== 1'b0 || bus.out !== held)) bad++;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_latency"}, lat, 32'd16);
    chk({tag, "_shift_hold"}, bad, 32'd0);
  endtask

  task automatic take(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_out"}, {16'd0, bus.out}, {16'd0, e.out});
      chk({tag, "_underflow"}, {31'd0, bus.underflow}, {31'd0, e.uf});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [15:0] num, input string tag);
    send(num, tag);
    wait_out(tag, 1'b0);
    take(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int          bad;
    logic [15:0] o;
    logic        u;

    bus.in_valid  = 1'b0;
    bus.in        = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out",       {16'd0, bus.out},       32'd0);
    chk("rst_underflow", {31'd0, bus.underflow}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h0001, "op0001");
    run_op(16'h0000, "op0000");
    run_op(16'h8000, "op8000");
    run_op(16'h1234, "op1234");
    run_op(16'hFFFF, "opFFFF");
    for (int i = 0; i < 4; i++) run_op(16'($urandom), "oprand");

    // Back-pressure: result must hold while out_ready stays low.
    send(16'h00A0, "bp");
    wait_out("bp", 1'b0);
    o   = bus.out;
    u   = bus.underflow;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.out !== o || bus.underflow !== u || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
    end
    chk("bp_stable", bad, 32'd0);
    take("bp");

    // Operand changes during SHIFT are ignored.
    send(16'h4321, "jam");
    wait_out("jam", 1'b1);
    take("jam");

    // Reset mid-shift aborts the operation.
    send(16'h5555, "abort");
    repeat (6) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    chk("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_out",       {16'd0, bus.out},       32'd0);
    chk("abort_underflow", {31'd0, bus.underflow}, 32'd0);
    void'(sb.pop_back());
    @(posedge clk); #1;
    reset_n = 1'b1;
    bad = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
    end
    chk("abort_no_result", bad, 32'd0);
    run_op(16'h0010, "post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/my_serial_dec16.md
# my_serial_dec16

Bit-serial 16-bit decrementer: the counterpart to the arithmetic library's ripple incrementer. It accepts a 16-bit word over a valid/ready handshake and subtracts one, one bit per clock, through a single borrow flip-flop. It then presents the 16-bit result and an underflow flag over a second valid/ready handshake. It sits in the arithmetic directory for datapaths that trade latency for area, such as counters and address-step units.

## Interface

Parameters: none. Width is fixed at 16.

Bit order follows the arithmetic library convention: bit 15 is the least significant and bit 0 is the most significant. Numeric value = Σ in[15-i]·2^i. All hex values below are numeric values under this convention.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream offers a word.
- in_ready  output  1  block can accept a word.
- in  input  16  operand.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out  output  16  in − 1 (mod 2^16).
- underflow  output  1  high with the result when the operand was 0.

## Operation

- Internal state:
  - FSM with states IDLE, SHIFT and DONE.
  - 16-bit work register.
  - 16-bit result register.
  - 4-bit bit counter `cnt`.
  - 1-bit borrow register.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1 at a clock edge: load work←in, set borrow←1 and cnt←0, go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each cycle processes bit k = 15−cnt (LSB first), with b = work[k]:
    - result[k] ← b XOR borrow.
    - borrow ← borrow AND NOT b.
    - cnt ← cnt+1.
  - In the cycle where cnt=15 (bit 0 processed), go to DONE.
  - The borrow chain runs the full 16 cycles even after borrow clears. Latency is fixed, with no early exit.
- DONE:
  - out_valid=1. out = result register. underflow = final borrow (1 only when the operand was 0x0000).
  - in_ready=0.
  - On out_ready=1 at an edge, go to IDLE.
- in_valid is ignored outside IDLE. The block does not register a pending request, so upstream must hold in_valid until it sees in_ready.
- out and underflow change only on the edge that processes bit 0 and enters DONE. They hold their last values in IDLE and SHIFT.
- No combinational path runs from any input to any output. All outputs decode from registered state.

## Timing

- Reset (reset_n=0, asynchronous) forces:
  - state=IDLE.
  - in_ready=1, out_valid=0.
  - out=0x0000, underflow=0.
  - work, cnt and borrow cleared.
- Reset asserted mid-SHIFT or in DONE aborts the operation with no result emitted. The first edge after release behaves as IDLE.
- Input accepted at edge E (in_valid & in_ready) means SHIFT is active during cycles E+1..E+16. out_valid rises after edge E+16, so latency is 16 cycles.
- out_valid held with out_ready=1 means the result transfers at the first edge. in_ready rises after that edge, and the next operand can be accepted one edge later.
- Minimum initiation interval is 18 cycles: accept, 16 shift cycles, output transfer.
- Back-pressure: out_valid, out and underflow stay stable indefinitely while out_ready=0.
- Wrap-around: operand 0x0000 gives out=0xFFFF and underflow=1. Every other operand gives underflow=0.

## Test plan

- Operand 0x0001 (in[15]=1 only) → after 16 cycles out_valid=1, out=0x0000, underflow=0.
- Operand 0x0000 → out=0xFFFF (all bits 1), underflow=1.
- Operand 0x8000 (in[0]=1 only) → out=0x7FFF, underflow=0. Operand 0x1234 → out=0x1233.
- Hold out_ready=0 for 10 cycles after out_valid → out, underflow and out_valid are stable and in_ready=0. Raise out_ready → transfer on that edge, and in_ready=1 on the next cycle.
- Hold in_valid=1 with changing `in` during SHIFT → the changes have no effect. The result equals the operand captured at acceptance.
- Pulse reset_n low at shift cycle 7 → outputs immediately take their reset values. No out_valid follows. A new operand 0x0010 afterwards yields 0x000F.
